mips_mem_responder: RTL and testbench

//  Memory-side responder for the multicycle 8-bit MIPS core's byte-wide memory bus (adr/memread/memwrite/writedata -> memdata).

---
 rtl/mips_mem_responder.sv | 155 +++++++++++++++
 tb/tb_mips_mem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// Byte-wide RAM responder for the multicycle 8-bit MIPS core.
// Optional MMIO output port: define MIPS_MMIO_PORT_EN.
`timescale 1ns/1ps
module mips_mem_responder #(
    parameter int WIDTH   = 8,
    parameter int ADRBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_valid,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             cpu_reset,
    input  logic [WIDTH-1:0] adr,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
`ifdef MIPS_MMIO_PORT_EN
    output logic [WIDTH-1:0] mmio_out,
`endif
    output logic             proto_err
);

    localparam int DEPTH = 2 ** ADRBITS;
    localparam logic [ADRBITS-1:0] PTR_MAX = '1;
`ifdef MIPS_MMIO_PORT_EN
    localparam logic [WIDTH-1:0] MMIO_ADR = '1;
`endif

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ADRBITS-1:0] ld_ptr_q, ld_ptr_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               proto_err_q, proto_err_d;
`ifdef MIPS_MMIO_PORT_EN
    logic [WIDTH-1:0]   mmio_q, mmio_d;
`endif

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               mem_we;
    logic [ADRBITS-1:0] mem_wa;
    logic [WIDTH-1:0]   mem_wd;
    logic [ADRBITS-1:0] ram_adr;

    // Upper address bits alias when the RAM is smaller than the bus
    assign ram_adr = adr[ADRBITS-1:0];

    assign ld_ready  = (state_q == S_LOAD);
    assign cpu_reset = cpu_reset_q;
    assign proto_err = proto_err_q;
`ifdef MIPS_MMIO_PORT_EN
    assign mmio_out  = mmio_q;
`endif

    // Control registers; reset aborts any load or run in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_LOAD;
            ld_ptr_q    <= '0;
            cpu_reset_q <= 1'b1;
            proto_err_q <= 1'b0;
`ifdef MIPS_MMIO_PORT_EN
            mmio_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ld_ptr_q    <= ld_ptr_d;
            cpu_reset_q <= cpu_reset_d;
            proto_err_q <= proto_err_d;
`ifdef MIPS_MMIO_PORT_EN
            mmio_q      <= mmio_d;
`endif
        end
    end

    // RAM array; contents survive reset so a short reload keeps the tail
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // Next-state, loader pointer, RAM write port and error tracking
    always_comb begin
        state_d     = state_q;
        ld_ptr_d    = ld_ptr_q;
        proto_err_d = proto_err_q;
        mem_we      = 1'b0;
        mem_wa      = ram_adr;
        mem_wd      = writedata;
`ifdef MIPS_MMIO_PORT_EN
        mmio_d      = mmio_q;
`endif
        unique case (state_q)
            S_LOAD: begin
                if (ld_valid && ld_ready) begin
                    mem_we = 1'b1;
                    mem_wa = ld_ptr_q;
                    mem_wd = ld_data;
                    if (ld_last || (ld_ptr_q == PTR_MAX)) begin
                        state_d = S_RUN;
                    end else begin
                        ld_ptr_d = ld_ptr_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (memwrite) begin
`ifdef MIPS_MMIO_PORT_EN
                    if (adr == MMIO_ADR) begin
                        mmio_d = writedata;
                    end else begin
                        mem_we = 1'b1;
                    end
`else
                    mem_we = 1'b1;
`endif
                    if (memread) begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
        if (cpu_reset_q && (memread || memwrite)) begin
            proto_err_d = 1'b1;
        end
        cpu_reset_d = (state_d == S_LOAD);
    end

    // Zero-latency read path; returns pre-write data on a same-cycle write
    always_comb begin
        memdata = '0;
        if ((state_q == S_RUN) && memread) begin
`ifdef MIPS_MMIO_PORT_EN
            if (adr == MMIO_ADR) begin
                memdata = mmio_q;
            end else begin
                memdata = mem_q[ram_adr];
            end
`else
            memdata = mem_q[ram_adr];
`endif
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized bench for mips_mem_responder against a behavioural model.
// Define MIPS_MMIO_PORT_EN to also exercise the MMIO output port.
`timescale 1ns/1ps
module tb_mips_mem_responder;

    logic       clk;
    logic       reset;
    logic [7:0] ld_data;
    logic       ld_valid;
    logic       ld_last;
    logic       ld_ready;
    logic       cpu_reset;
    logic [7:0] adr;
    logic       memread;
    logic       memwrite;
    logic [7:0] writedata;
    logic [7:0] memdata;
    logic       proto_err;
`ifdef MIPS_MMIO_PORT_EN
    logic [7:0] mmio_out;
`endif

    mips_mem_responder #(.WIDTH(8), .ADRBITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_data   (ld_data),
        .ld_valid  (ld_valid),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .cpu_reset (cpu_reset),
        .adr       (adr),
        .memread   (memread),
        .memwrite  (memwrite),
        .writedata (writedata),
        .memdata   (memdata),
`ifdef MIPS_MMIO_PORT_EN
        .mmio_out  (mmio_out),
`endif
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: image RAM, load progress, error flag, MMIO register
    logic [7:0] ram_m   [256];
    bit         known_m [256];
    bit         run_m;
    int         ptr_m;
    bit         proto_m;
    logic [7:0] mmio_m;
    logic [7:0] last_md;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_mmio(input logic [7:0] a);
`ifdef MIPS_MMIO_PORT_EN
        return a == 8'hFF;
`else
        return 1'b0;
`endif
    endfunction

    // One bus cycle: drive, check combinational/registered outputs, advance model
    task automatic step(input bit v, input logic [7:0] d, input bit l,
                        input bit rd, input bit wr,
                        input logic [7:0] a, input logic [7:0] wd);
        int ai;
        @(negedge clk);
        ld_valid = v; ld_data = d; ld_last = l;
        memread = rd; memwrite = wr; adr = a; writedata = wd;
        #2;
        ai = int'(a);
        last_md = memdata;
        check("ld_ready", {31'd0, ld_ready}, {31'd0, !run_m});
        check("cpu_reset", {31'd0, cpu_reset}, {31'd0, !run_m});
        check("proto_err", {31'd0, proto_err}, {31'd0, proto_m});
`ifdef MIPS_MMIO_PORT_EN
        check("mmio_out", {24'd0, mmio_out}, {24'd0, mmio_m});
`endif
        if (!run_m || !rd) begin
            check("memdata_idle", {24'd0, memdata}, 32'd0);
        end else if (is_mmio(a)) begin
            check("memdata_mmio", {24'd0, memdata}, {24'd0, mmio_m});
        end else if (known_m[ai]) begin
            check("memdata", {24'd0, memdata}, {24'd0, ram_m[ai]});
        end
        @(posedge clk);
        if (!run_m) begin
            if (rd || wr) proto_m = 1'b1;
            if (v) begin
                ram_m[ptr_m]   = d;
                known_m[ptr_m] = 1'b1;
                if (l || ptr_m == 255) run_m = 1'b1;
                else ptr_m++;
            end
        end else if (wr) begin
            if (rd) proto_m = 1'b1;
            if (is_mmio(a)) mmio_m = wd;
            else begin
                ram_m[ai]   = wd;
                known_m[ai] = 1'b1;
            end
        end
    endtask

    task automatic idle_inputs();
        ld_valid = 0; ld_data = 0; ld_last = 0;
        memread = 0; memwrite = 0; adr = 0; writedata = 0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must respond at once
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        #1 reset = 1'b1;
        #1;
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        check("rst_memdata", {24'd0, memdata}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_m = 0; ptr_m = 0; proto_m = 0; mmio_m = 8'h00;
    endtask

    task automatic rd_at(input logic [7:0] a);
        step(0, 8'h00, 0, 1, 0, a, 8'h00);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1),
                 $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                 8'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_m[i] = 8'h00;
            known_m[i] = 1'b0;
        end
        run_m = 0; ptr_m = 0; proto_m = 0; mmio_m = 8'h00;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        do_reset();

        // Small image with a 5-cycle loader stall in the middle
        step(1, 8'h20, 0, 0, 0, 8'h00, 8'h00);
        step(1, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        repeat (5) step(0, 8'h99, 1, 0, 0, 8'h00, 8'h00);
        step(1, 8'h01, 0, 0, 0, 8'h00, 8'h00);
        check("still_load", {31'd0, run_m}, 32'd0);
        step(1, 8'h80, 1, 0, 0, 8'h00, 8'h00);
        #1;
        check("cpu_rst_fall", {31'd0, cpu_reset}, 32'd0);
        check("ld_ready_fall", {31'd0, ld_ready}, 32'd0);
        rd_at(8'h00); check("img0", {24'd0, last_md}, 32'h20);
        rd_at(8'h01); check("img1", {24'd0, last_md}, 32'h00);
        rd_at(8'h02); check("img2", {24'd0, last_md}, 32'h01);
        rd_at(8'h03); check("img3", {24'd0, last_md}, 32'h80);
        check("proto_clean", {31'd0, proto_err}, 32'd0);

        // Write then read back; no strobe gives zero
        step(0, 8'h00, 0, 0, 1, 8'h40, 8'hA5);
        rd_at(8'h40); check("wr_rd_40", {24'd0, last_md}, 32'hA5);
        step(0, 8'h00, 0, 0, 0, 8'h40, 8'h00);
        check("no_read_zero", {24'd0, last_md}, 32'h00);

        // Simultaneous read and write
        step(0, 8'h00, 0, 0, 1, 8'h10, 8'h11);
        step(0, 8'h00, 0, 1, 1, 8'h10, 8'h22);
        check("rw_old_data", {24'd0, last_md}, 32'h11);
        rd_at(8'h10); check("rw_new_data", {24'd0, last_md}, 32'h22);
        check("rw_proto", {31'd0, proto_err}, 32'd1);

        // Reset mid-run then a 2-byte reload keeps the rest of the image
        do_reset();
        step(1, 8'hAA, 0, 0, 0, 8'h00, 8'h00);
        step(1, 8'hBB, 1, 0, 0, 8'h00, 8'h00);
        rd_at(8'h00); check("reload0", {24'd0, last_md}, 32'hAA);
        rd_at(8'h01); check("reload1", {24'd0, last_md}, 32'hBB);
        rd_at(8'h02); check("retain2", {24'd0, last_md}, 32'h01);
        rd_at(8'h03); check("retain3", {24'd0, last_md}, 32'h80);
        rd_at(8'h40); check("retain40", {24'd0, last_md}, 32'hA5);

        random_run(300);

        // Full image without ld_last, then an extra byte that must be dropped
        do_reset();
        while (!run_m) begin
            if ($urandom_range(0, 3) == 0) step(0, 8'($urandom), 0, 0, 0, 8'h00, 8'h00);
            else step(1, 8'($urandom), 0, 0, 0, 8'h00, 8'h00);
        end
        check("full_ptr", ptr_m, 255);
        #1;
        check("full_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        step(1, 8'hEE, 0, 0, 0, 8'h00, 8'h00);
        rd_at(8'h00);
        check("extra_dropped", {24'd0, last_md}, {24'd0, ram_m[0]});
        for (int i = 0; i < 256; i++) rd_at(8'(i));
        check("proto_after_full", {31'd0, proto_err}, 32'd0);

        random_run(400);

`ifdef MIPS_MMIO_PORT_EN
        begin
            logic [7:0] ram_ff;
            ram_ff = dut.mem_q[255];
            step(0, 8'h00, 0, 0, 1, 8'hFF, 8'h5A);
            #1;
            check("mmio_set", {24'd0, mmio_out}, 32'h5A);
            check("mmio_ram_kept", {24'd0, dut.mem_q[255]}, {24'd0, ram_ff});
            rd_at(8'hFF); check("mmio_read", {24'd0, last_md}, 32'h5A);
        end
`endif

        // Random image length with stray core strobes during load
        do_reset();
        for (int i = 0; i < 600 && !run_m; i++) begin
            step($urandom_range(0, 1), 8'($urandom), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 8'($urandom), 8'($urandom));
        end
        random_run(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
